// File: rtl/vga_sprite_renderer_pkg.sv
// Shared VGA constants, RGB444 colour type and the final colour-priority mux.
`timescale 1ns/1ps
package vga_sprite_renderer_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int RGB_W    = 12;

  typedef logic [RGB_W-1:0] rgb_t;

  localparam rgb_t COLOR_BLACK = 12'h000;
  localparam rgb_t COLOR_GREY  = 12'h555;
  localparam rgb_t COLOR_WHITE = 12'hFFF;

  // Blank beats sprite, sprite beats ground, ground beats background.
  function automatic rgb_t pick_colour(input logic blank, input logic spr, input logic gnd,
                                       input rgb_t fg, input rgb_t gnd_c, input rgb_t bg);
    rgb_t c;
    if (blank)    c = COLOR_BLACK;
    else if (spr) c = fg;
    else if (gnd) c = gnd_c;
    else          c = bg;
    return c;
  endfunction

endpackage

// File: rtl/vga_sprite_renderer_rom.sv
// 1-bpp sprite bitmap, four animation frames, one-cycle registered read.
// Contents are generated procedurally from the address (frame/row/column) so the
// image is fixed at elaboration without an external memory file.
`timescale 1ns/1ps
module sprite_rom
  import vga_sprite_renderer_pkg::*;
#(
  parameter int SPR_W = 32,
  parameter int SPR_H = 32,
  parameter int AW    = 2 + $clog2(SPR_W) + $clog2(SPR_H)
) (
  input  logic          pixel_clock,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  output logic          pix
);

  localparam int XW = $clog2(SPR_W);
  localparam int YW = $clog2(SPR_H);

  logic [1:0]    w_frame;
  logic [YW-1:0] w_row;
  logic [XW-1:0] w_col;
  logic          w_bit;
  logic          r_pix;

  assign w_frame = addr[AW-1 -: 2];
  assign w_row   = addr[XW +: YW];
  assign w_col   = addr[XW-1:0];
  // Checkerboard body; frame bit 0 inverts it, frame bit 1 shifts alternate row pairs.
  assign w_bit   = (w_row[0] ~^ w_col[0]) ^ w_frame[0] ^ (w_frame[1] & w_row[1]);
  assign pix     = r_pix;

  // Registered read: address in one cycle, pixel bit out the next.
  always_ff @(posedge pixel_clock or posedge rst) begin
    if (rst) r_pix <= 1'b0;
    else     r_pix <= w_bit;
  end

endmodule

// File: rtl/vga_sprite_renderer.sv
// Pixel-colour stage behind the 640x480 timing generator: frame-synchronous sprite
// shadow registers, 3-stage pixel pipeline, colour priority mux, re-aligned syncs.
`timescale 1ns/1ps
module vga_sprite_renderer
  import vga_sprite_renderer_pkg::*;
#(
  parameter int   SPR_W        = 32,
  parameter int   SPR_H        = 32,
  parameter int   GROUND_Y     = 400,
  parameter rgb_t FG_COLOR     = COLOR_BLACK,
  parameter rgb_t GROUND_COLOR = COLOR_GREY,
  parameter rgb_t BG_COLOR     = COLOR_WHITE
) (
  input  logic       pixel_clock,
  input  logic       rst,
  input  logic [9:0] x_in,
  input  logic [8:0] y_in,
  input  logic       blank_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [9:0] spr_x_req,
  input  logic [8:0] spr_y_req,
  input  logic [1:0] spr_frame,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       blank_out,
  output logic       frame_tick
);

  localparam int XW = $clog2(SPR_W);
  localparam int YW = $clog2(SPR_H);
  localparam int AW = 2 + XW + YW;

  // Shadow registers and vsync edge detect
  logic       r_vsync_prev;
  logic [9:0] r_sx;
  logic [8:0] r_sy;
  logic [1:0] r_frame;
  logic       r_frame_tick;
  logic       w_vs_fall;

  assign w_vs_fall = r_vsync_prev & ~vsync_in;

  // Load the sprite request on vsync falling edge; tick marks the new values being live.
  always_ff @(posedge pixel_clock or posedge rst) begin
    if (rst) begin
      r_vsync_prev <= 1'b1;
      r_sx         <= '0;
      r_sy         <= '0;
      r_frame      <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_vsync_prev <= vsync_in;
      r_frame_tick <= w_vs_fall;
      if (w_vs_fall) begin
        r_sx    <= spr_x_req;
        r_sy    <= spr_y_req;
        r_frame <= spr_frame;
      end
    end
  end

  // ---- S1: sprite box test, ROM address, ground detect ----
  logic [10:0]   w_x_end;
  logic [9:0]    w_y_end;
  logic [XW-1:0] w_dx;
  logic [YW-1:0] w_dy;
  logic          w_in_box;
  logic          w_gnd;

  // Extra MSB on the end coordinates keeps a sprite near the right/bottom edge from wrapping.
  assign w_x_end  = {1'b0, r_sx} + 11'(SPR_W);
  assign w_y_end  = {1'b0, r_sy} + 10'(SPR_H);
  assign w_in_box = (x_in >= r_sx) && ({1'b0, x_in} < w_x_end) &&
                    (y_in >= r_sy) && ({1'b0, y_in} < w_y_end);
  assign w_dx     = x_in[XW-1:0] - r_sx[XW-1:0];
  assign w_dy     = y_in[YW-1:0] - r_sy[YW-1:0];
  assign w_gnd    = (y_in == 9'(GROUND_Y));

  logic          r_in_box_p1, r_gnd_p1, r_blank_p1, r_hs_p1, r_vs_p1;
  logic [AW-1:0] r_addr_p1;

  // Stage 1 registers.
  always_ff @(posedge pixel_clock or posedge rst) begin
    if (rst) begin
      r_in_box_p1 <= 1'b0;
      r_gnd_p1    <= 1'b0;
      r_blank_p1  <= 1'b1;
      r_hs_p1     <= 1'b1;
      r_vs_p1     <= 1'b1;
      r_addr_p1   <= '0;
    end else begin
      r_in_box_p1 <= w_in_box;
      r_gnd_p1    <= w_gnd;
      r_blank_p1  <= blank_in;
      r_hs_p1     <= hsync_in;
      r_vs_p1     <= vsync_in;
      r_addr_p1   <= {r_frame, w_dy, w_dx};
    end
  end

  // ---- S2: ROM read, side-band delayed alongside ----
  logic w_pix_p2;

  sprite_rom #(.SPR_W(SPR_W), .SPR_H(SPR_H), .AW(AW)) u_rom (
    .pixel_clock (pixel_clock),
    .rst         (rst),
    .addr        (r_addr_p1),
    .pix         (w_pix_p2)
  );

  logic r_in_box_p2, r_gnd_p2, r_blank_p2, r_hs_p2, r_vs_p2;

  // Stage 2 registers, matching the ROM read latency.
  always_ff @(posedge pixel_clock or posedge rst) begin
    if (rst) begin
      r_in_box_p2 <= 1'b0;
      r_gnd_p2    <= 1'b0;
      r_blank_p2  <= 1'b1;
      r_hs_p2     <= 1'b1;
      r_vs_p2     <= 1'b1;
    end else begin
      r_in_box_p2 <= r_in_box_p1;
      r_gnd_p2    <= r_gnd_p1;
      r_blank_p2  <= r_blank_p1;
      r_hs_p2     <= r_hs_p1;
      r_vs_p2     <= r_vs_p1;
    end
  end

  // ---- S3: colour select and output registers ----
  rgb_t r_rgb;
  logic r_hs_out, r_vs_out, r_blank_out;

  // Stage 3 registers: final colour with syncs and blank aligned to it.
  always_ff @(posedge pixel_clock or posedge rst) begin
    if (rst) begin
      r_rgb       <= COLOR_BLACK;
      r_hs_out    <= 1'b1;
      r_vs_out    <= 1'b1;
      r_blank_out <= 1'b1;
    end else begin
      r_rgb       <= pick_colour(r_blank_p2, r_in_box_p2 & w_pix_p2, r_gnd_p2,
                                 FG_COLOR, GROUND_COLOR, BG_COLOR);
      r_hs_out    <= r_hs_p2;
      r_vs_out    <= r_vs_p2;
      r_blank_out <= r_blank_p2;
    end
  end

  assign red        = r_rgb[11:8];
  assign green      = r_rgb[7:4];
  assign blue       = r_rgb[3:0];
  assign hsync_out  = r_hs_out;
  assign vsync_out  = r_vs_out;
  assign blank_out  = r_blank_out;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_vga_sprite_renderer.sv
// Directed bench for vga_sprite_renderer: reset, sync alignment, sprite draw,
// frame-synchronous position update, clipping, priority and blank override.
`timescale 1ns/1ps
module tb_vga_sprite_renderer;

  logic       pixel_clock = 1'b0;
  logic       rst;
  logic [9:0] x_in;
  logic [8:0] y_in;
  logic       blank_in, hsync_in, vsync_in;
  logic [9:0] spr_x_req;
  logic [8:0] spr_y_req;
  logic [1:0] spr_frame;
  logic [3:0] red, green, blue;
  logic       hsync_out, vsync_out, blank_out, frame_tick;

  logic [11:0] w_rgb;
  assign w_rgb = {red, green, blue};

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [11:0] FG  = 12'h000;
  localparam logic [11:0] GND = 12'h555;
  localparam logic [11:0] BG  = 12'hFFF;

  vga_sprite_renderer dut (
    .pixel_clock (pixel_clock),
    .rst         (rst),
    .x_in        (x_in),
    .y_in        (y_in),
    .blank_in    (blank_in),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .spr_x_req   (spr_x_req),
    .spr_y_req   (spr_y_req),
    .spr_frame   (spr_frame),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out),
    .blank_out   (blank_out),
    .frame_tick  (frame_tick)
  );

  always #20 pixel_clock = ~pixel_clock;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge pixel_clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %03h expected %03h", tag, obs, exp);
    end
  endtask

  task automatic pixel(input int x, input int y, input logic [11:0] exp, input string tag);
    x_in = 10'(x);
    y_in = 9'(y);
    tick(3);
    check(tag, w_rgb, exp);
  endtask

  task automatic vedge(input string tag);
    vsync_in = 1'b0;
    tick(1);
    check({tag, "_tick_hi"}, {11'd0, frame_tick}, 12'd1);
    tick(1);
    check({tag, "_tick_lo"}, {11'd0, frame_tick}, 12'd0);
    vsync_in = 1'b1;
    tick(1);
  endtask

  initial begin
    rst = 1'b1;
    x_in = '0; y_in = '0;
    blank_in = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
    spr_x_req = '0; spr_y_req = '0; spr_frame = '0;
    tick(4);
    check("rst_rgb",   w_rgb, 12'h000);
    check("rst_hs",    {11'd0, hsync_out}, 12'd1);
    check("rst_vs",    {11'd0, vsync_out}, 12'd1);
    check("rst_blank", {11'd0, blank_out}, 12'd1);
    check("rst_tick",  {11'd0, frame_tick}, 12'd0);

    // Release reset; first visible background pixel appears 3 cycles later.
    rst = 1'b0;
    blank_in = 1'b0; x_in = 10'd500; y_in = 9'd10;
    tick(2);
    check("lat2_blank", {11'd0, blank_out}, 12'd1);
    check("lat2_rgb",   w_rgb, 12'h000);
    tick(1);
    check("lat3_blank", {11'd0, blank_out}, 12'd0);
    check("lat3_rgb",   w_rgb, BG);

    // Sync/blank alignment.
    hsync_in = 1'b0;
    tick(2);
    check("hs_lat2", {11'd0, hsync_out}, 12'd1);
    tick(1);
    check("hs_lat3", {11'd0, hsync_out}, 12'd0);
    hsync_in = 1'b1;
    blank_in = 1'b1;
    tick(2);
    check("bl_lat2", {11'd0, blank_out}, 12'd0);
    tick(1);
    check("bl_lat3",     {11'd0, blank_out}, 12'd1);
    check("bl_lat3_rgb", w_rgb, 12'h000);
    check("hs_back",     {11'd0, hsync_out}, 12'd1);
    blank_in = 1'b0;

    // Sprite at (100,200), frame 0.
    spr_x_req = 10'd100; spr_y_req = 9'd200; spr_frame = 2'd0;
    vedge("edge1");
    check("vs_out_low", {11'd0, vsync_out}, 12'd0);
    pixel(100, 200, FG,  "spr_origin");
    pixel(101, 200, BG,  "spr_transp");
    pixel(131, 201, FG,  "spr_lastcol");
    pixel(132, 200, BG,  "spr_right_out");
    pixel(100, 232, BG,  "spr_below_out");
    pixel(99,  200, BG,  "spr_left_out");

    // Request change mid-frame is ignored until the next vsync edge.
    spr_x_req = 10'd300;
    pixel(100, 200, FG, "hold_old_pos");
    check("no_tick_midframe", {11'd0, frame_tick}, 12'd0);
    vedge("edge2");
    pixel(100, 200, BG, "old_pos_gone");
    pixel(300, 200, FG, "new_pos");

    // Clipping at right/bottom, priority over ground.
    spr_x_req = 10'd630; spr_y_req = 9'd395; spr_frame = 2'd0;
    vedge("edge3");
    pixel(630, 400, GND, "clip_transp_gnd");
    pixel(631, 400, FG,  "clip_spr_over_gnd");
    pixel(639, 400, FG,  "clip_last_col");
    pixel(1,   396, BG,  "clip_no_wrap");
    pixel(0,   400, GND, "gnd_left");
    pixel(629, 399, BG,  "clip_left_out");

    // Frame 1 inverts the checkerboard.
    spr_frame = 2'd1;
    vedge("edge4");
    pixel(630, 400, FG,  "frame1_pix");
    pixel(631, 400, GND, "frame1_transp");

    // Blank overrides sprite.
    blank_in = 1'b1;
    pixel(630, 400, 12'h000, "blank_over_spr");
    check("blank_out_hi", {11'd0, blank_out}, 12'd1);
    blank_in = 1'b0;
    pixel(630, 400, FG, "unblank");

    // Asynchronous reset mid-frame clears outputs and shadows.
    #5 rst = 1'b1;
    #1;
    check("arst_rgb",   w_rgb, 12'h000);
    check("arst_blank", {11'd0, blank_out}, 12'd1);
    tick(1);
    rst = 1'b0;
    pixel(630, 400, GND, "post_rst_shadow_clear");
    pixel(0,   0,   FG,  "post_rst_origin");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
